// File: rtl/regfile_scoreboard.sv
// Integer register file with zero-latency reads and a per-register busy scoreboard.
// Optional same-cycle write forwarding to the read ports is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned NRD  = 2,
  localparam int unsigned AW  = $clog2(NREG),
  localparam int unsigned CW  = $clog2(NREG + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*XLEN-1:0]   rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  issue_valid,
  input  logic [AW-1:0]         issue_addr,
  output logic                  issue_ready,
  output logic [CW-1:0]         busy_count
);

  // Entry 0 is held at zero and never written, so reads of x0 need no special case.
  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_busy;
  logic [CW-1:0]   r_busy_count;

  logic            w_wr;
  logic            w_set;
  logic            w_inc;
  logic            w_dec;
  logic [NREG-1:0] w_busy_nxt;
  logic [CW-1:0]   w_busy_count_nxt;

  assign w_wr        = wr_en && (wr_addr != '0);
  assign issue_ready = (issue_addr == '0) || !r_busy[issue_addr];
  assign w_set       = issue_valid && issue_ready && (issue_addr != '0);

  // A set only lands on a free register; a clear only counts if the flag was set and not re-set.
  assign w_inc = w_set;
  assign w_dec = w_wr && r_busy[wr_addr] && !(w_set && (issue_addr == wr_addr));

  // Scoreboard next state: clear on writeback, set on issue, set wins on collision.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr) begin
      w_busy_nxt[wr_addr] = 1'b0;
    end
    if (w_set) begin
      w_busy_nxt[issue_addr] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  assign w_busy_count_nxt = r_busy_count + CW'(w_inc) - CW'(w_dec);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++) begin
        r_regs[k] <= '0;
      end
      r_busy       <= '0;
      r_busy_count <= '0;
    end else begin
      if (w_wr) begin
        r_regs[wr_addr] <= wr_data;
      end
      r_busy       <= w_busy_nxt;
      r_busy_count <= w_busy_count_nxt;
    end
  end

  assign busy_count = r_busy_count;

  // Independent read ports.
  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] w_ra;
    assign w_ra = rd_addr[g*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    logic w_fwd;
    assign w_fwd = w_wr && (wr_addr == w_ra);
    assign rd_data[g*XLEN +: XLEN] = w_fwd ? wr_data : r_regs[w_ra];
    assign rd_busy[g]              = w_fwd ? 1'b0 : r_busy[w_ra];
`else
    assign rd_data[g*XLEN +: XLEN] = r_regs[w_ra];
    assign rd_busy[g]              = r_busy[w_ra];
`endif
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (default parameters, two read ports).
module tb_regfile_scoreboard;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned NRD  = 2;
  localparam int unsigned AW   = 5;
  localparam int unsigned CW   = 6;

  logic                clk;
  logic                rst;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                issue_valid;
  logic [AW-1:0]       issue_addr;
  logic                issue_ready;
  logic [CW-1:0]       busy_count;

  int n_cmp;
  int n_err;

  regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .issue_ready (issue_ready),
    .busy_count  (busy_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rst         = 1'b1;
    rd_addr     = '0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    issue_valid = 1'b0;
    issue_addr  = '0;
    tick();
    rst = 1'b0;
    #1;

    // Post-reset sweep of every address on both ports.
    for (int a = 0; a < 32; a++) begin
      set_rd(a, 31 - a);
      issue_addr = AW'(a);
      #1;
      check("rst_rd0",   rd_data[31:0],  32'h0);
      check("rst_rd1",   rd_data[63:32], 32'h0);
      check("rst_busy",  32'(rd_busy),   32'h0);
      check("rst_ready", 32'(issue_ready), 32'h1);
    end
    check("rst_count", 32'(busy_count), 32'h0);

    // WAW stall on x5, then writeback clears it.
    issue_valid = 1'b1;
    issue_addr  = 5'd5;
    set_rd(5, 0);
    #1;
    check("x5_ready_first", 32'(issue_ready), 32'h1);
    tick();
    check("x5_ready_stall", 32'(issue_ready), 32'h0);
    check("x5_count_1",     32'(busy_count),  32'h1);
    check("x5_rd_busy",     32'(rd_busy),     32'h1);
    tick();
    check("x5_count_hold",  32'(busy_count),  32'h1);
    issue_valid = 1'b0;
    wr_en   = 1'b1;
    wr_addr = 5'd5;
    wr_data = 32'hDEADBEEF;
    tick();
    wr_en = 1'b0;
    #1;
    check("x5_busy_clr", 32'(rd_busy),     32'h0);
    check("x5_count_0",  32'(busy_count),  32'h0);
    check("x5_data",     rd_data[31:0],    32'hDEADBEEF);

    // Issue and write to x7 in the same cycle: data lands, busy ends set.
    issue_valid = 1'b1;
    issue_addr  = 5'd7;
    wr_en   = 1'b1;
    wr_addr = 5'd7;
    wr_data = 32'h12345678;
    set_rd(7, 7);
    tick();
    issue_valid = 1'b0;
    wr_en = 1'b0;
    #1;
    check("x7_busy",  32'(rd_busy),    32'h3);
    check("x7_data",  rd_data[31:0],   32'h12345678);
    check("x7_count", 32'(busy_count), 32'h1);
    wr_en   = 1'b1;
    wr_addr = 5'd7;
    wr_data = 32'h12345678;
    tick();
    wr_en = 1'b0;
    #1;
    check("x7_count_clr", 32'(busy_count), 32'h0);

    // x0 is never reserved and never written.
    issue_valid = 1'b1;
    issue_addr  = 5'd0;
    wr_en   = 1'b1;
    wr_addr = 5'd0;
    wr_data = 32'hFFFFFFFF;
    set_rd(0, 0);
    #1;
    check("x0_ready", 32'(issue_ready), 32'h1);
    tick();
    issue_valid = 1'b0;
    wr_en = 1'b0;
    #1;
    check("x0_count", 32'(busy_count), 32'h0);
    check("x0_data0", rd_data[31:0],   32'h0);
    check("x0_data1", rd_data[63:32],  32'h0);
    check("x0_busy",  32'(rd_busy),    32'h0);

    // Same-cycle read of a register being written.
    wr_en   = 1'b1;
    wr_addr = 5'd3;
    wr_data = 32'h11111111;
    tick();
    wr_data = 32'hA5A5A5A5;
    set_rd(3, 3);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("x3_same_rd0", rd_data[31:0],  32'hA5A5A5A5);
    check("x3_same_rd1", rd_data[63:32], 32'hA5A5A5A5);
`else
    check("x3_same_rd0", rd_data[31:0],  32'h11111111);
    check("x3_same_rd1", rd_data[63:32], 32'h11111111);
`endif
    tick();
    wr_en = 1'b0;
    #1;
    check("x3_next_rd0", rd_data[31:0],  32'hA5A5A5A5);
    check("x3_next_rd1", rd_data[63:32], 32'hA5A5A5A5);

    // Busy flag during a writeback to the register being read.
    issue_valid = 1'b1;
    issue_addr  = 5'd9;
    tick();
    issue_valid = 1'b0;
    set_rd(9, 3);
    #1;
    check("x9_busy_pre", 32'(rd_busy), 32'h1);
    wr_en   = 1'b1;
    wr_addr = 5'd9;
    wr_data = 32'h00C0FFEE;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("x9_busy_wr", 32'(rd_busy),   32'h0);
    check("x9_data_wr", rd_data[31:0],  32'h00C0FFEE);
`else
    check("x9_busy_wr", 32'(rd_busy),   32'h1);
    check("x9_data_wr", rd_data[31:0],  32'h0);
`endif
    tick();
    wr_en = 1'b0;
    #1;
    check("x9_count", 32'(busy_count), 32'h0);
    check("x9_data",  rd_data[31:0],   32'h00C0FFEE);

    // Fill the scoreboard, then reset alongside a write and a pending issue.
    issue_valid = 1'b1;
    for (int a = 1; a < 32; a++) begin
      issue_addr = AW'(a);
      #1;
      if (a == 16) begin
        check("fill_ready_16", 32'(issue_ready), 32'h1);
        check("fill_count_15", 32'(busy_count),  32'd15);
      end
      tick();
    end
    issue_addr = 5'd20;
    #1;
    check("fill_count_31", 32'(busy_count),  32'd31);
    check("fill_stall",    32'(issue_ready), 32'h0);
    rst     = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 5'd4;
    wr_data = 32'hCAFEF00D;
    tick();
    rst         = 1'b0;
    wr_en       = 1'b0;
    issue_valid = 1'b0;
    set_rd(4, 3);
    #1;
    check("post_rst_count", 32'(busy_count),  32'h0);
    check("post_rst_x4",    rd_data[31:0],    32'h0);
    check("post_rst_x3",    rd_data[63:32],   32'h0);
    check("post_rst_busy",  32'(rd_busy),     32'h0);
    check("post_rst_ready", 32'(issue_ready), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
